// File: rtl/execute_pipe.sv
// execute_pipe: execute stage of the three-stage RISC-V core.
// Single-cycle RV32I ALU, branch/jump resolution and load/store address
// generation, plus an iterative RV32M unit that handles one bit per cycle.
// The results go to a registered valid/ready output slot.
//
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready    : decode handshake
//   pc, reg_rdata1/2, immediate, immediate_sel : operands
//   alu..mem_to_reg      : one-hot operation class
//   alu_operation        : funct3
//   arithsubtype         : SUB/SRA select
//   dest_reg_sel         : rd
//   out_valid/out_ready  : writeback handshake
//   out_result, out_addr, out_dest_reg, out_mem_write, out_mem_to_reg
//   redirect, redirect_pc: taken branch/jump, qualified by out_valid
module execute_pipe #(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] RESET = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg_rdata1,
    input  logic [XLEN-1:0] reg_rdata2,
    input  logic [XLEN-1:0] immediate,
    input  logic            immediate_sel,
    input  logic            alu,
    input  logic            muldiv,
    input  logic            branch,
    input  logic            lui,
    input  logic            jal,
    input  logic            jalr,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic [2:0]      alu_operation,
    input  logic            arithsubtype,
    input  logic [4:0]      dest_reg_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [XLEN-1:0] out_addr,
    output logic [4:0]      out_dest_reg,
    output logic            out_mem_write,
    output logic            out_mem_to_reg,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;   // product high half / remainder
    logic [XLEN-1:0]   mq_q, mq_d;     // multiplier+product low / quotient
    logic [XLEN-1:0]   b_q, b_d;       // multiplicand / divisor magnitude
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [4:0]        rd_q, rd_d;

    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_result_q, out_result_d;
    logic [XLEN-1:0]   out_addr_q, out_addr_d;
    logic [4:0]        out_dest_q, out_dest_d;
    logic              out_mw_q, out_mw_d;
    logic              out_mr_q, out_mr_d;
    logic              redirect_q, redirect_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;

    logic [XLEN-1:0]   op2, add_res, alu_res, agen, ptgt, pc4, sc_res, fix_res;
    logic [XLEN:0]     udiff, bdiff, mul_sum, div_sh, div_diff;
    logic [SHW-1:0]    shamt;
    logic              slt, sltu, beq, blt, bltu, taken, accept;
    logic              a_sgn, b_sgn, a_neg, b_neg, div0, ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        // ---- single-cycle datapath ----
        op2     = immediate_sel ? immediate : reg_rdata2;
        add_res = reg_rdata1 + op2;
        udiff   = {1'b0, reg_rdata1} - {1'b0, op2};
        sltu    = udiff[XLEN];
        // Signed compare from the unsigned borrow: flip when signs differ.
        slt     = udiff[XLEN] ^ reg_rdata1[XLEN-1] ^ op2[XLEN-1];
        shamt   = op2[SHW-1:0];
        unique case (alu_operation)
            3'd0:    alu_res = arithsubtype ? udiff[XLEN-1:0] : add_res;
            3'd1:    alu_res = reg_rdata1 << shamt;
            3'd2:    alu_res = {{(XLEN-1){1'b0}}, slt};
            3'd3:    alu_res = {{(XLEN-1){1'b0}}, sltu};
            3'd4:    alu_res = reg_rdata1 ^ op2;
            3'd5:    alu_res = arithsubtype ? $unsigned($signed(reg_rdata1) >>> shamt)
                                            : reg_rdata1 >> shamt;
            3'd6:    alu_res = reg_rdata1 | op2;
            default: alu_res = reg_rdata1 & op2;
        endcase

        bdiff = {1'b0, reg_rdata1} - {1'b0, reg_rdata2};
        beq   = (bdiff[XLEN-1:0] == '0);
        bltu  = bdiff[XLEN];
        blt   = bdiff[XLEN] ^ reg_rdata1[XLEN-1] ^ reg_rdata2[XLEN-1];
        unique case (alu_operation)
            3'd0:    taken = beq;
            3'd1:    taken = !beq;
            3'd4:    taken = blt;
            3'd5:    taken = !blt;
            3'd6:    taken = bltu;
            3'd7:    taken = !bltu;
            default: taken = 1'b0;
        endcase

        agen = reg_rdata1 + immediate;
        ptgt = pc + immediate;
        pc4  = pc + XLEN'(4);

        // ---- muldiv operand preparation ----
        a_sgn = alu_operation[2] ? !alu_operation[0] : (alu_operation[1:0] != 2'b11);
        b_sgn = alu_operation[2] ? !alu_operation[0] : !alu_operation[1];
        a_neg = a_sgn && reg_rdata1[XLEN-1];
        b_neg = b_sgn && reg_rdata2[XLEN-1];
        a_mag = a_neg ? -reg_rdata1 : reg_rdata1;
        b_mag = b_neg ? -reg_rdata2 : reg_rdata2;
        div0  = (reg_rdata2 == '0);
        ovf   = !alu_operation[0] && (reg_rdata1 == {1'b1, {(XLEN-1){1'b0}}})
                && (&reg_rdata2);
        special  = alu_operation[2] && (div0 || ovf);
        if (div0) spec_res = alu_operation[1] ? reg_rdata1 : '1;
        else      spec_res = alu_operation[1] ? '0 : reg_rdata1;

        if (muldiv)                    sc_res = spec_res;
        else if (lui)                  sc_res = immediate;
        else if (jal || jalr)          sc_res = pc4;
        else if (mem_write)            sc_res = reg_rdata2;
        else if (alu)                  sc_res = alu_res;
        else                           sc_res = '0;

        // ---- iteration and sign fix ----
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {acc_q, mq_q[XLEN-1]};
        div_diff = div_sh - {1'b0, b_q};
        prod     = {acc_q, mq_q};
        prod_s   = neg_q ? -prod : prod;
        if (op_q[2])
            fix_res = op_q[1] ? (neg_q ? -acc_q : acc_q) : (neg_q ? -mq_q : mq_q);
        else
            fix_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

        // ---- control ----
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rd_d    = rd_q;

        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_addr_d   = out_addr_q;
        out_dest_d   = out_dest_q;
        out_mw_d     = out_mw_q;
        out_mr_d     = out_mr_q;
        redirect_d   = redirect_q;
        rpc_d        = rpc_q;

        unique case (state_q)
            IDLE: if (accept) begin
                if (muldiv && !special) begin
                    state_d = alu_operation[2] ? DIV : MUL;
                    cnt_d   = SHW'(XLEN-1);
                    acc_d   = '0;
                    mq_d    = a_mag;
                    b_d     = b_mag;
                    op_d    = alu_operation;
                    // Remainder follows the dividend sign only.
                    neg_d   = (alu_operation[2] && alu_operation[1]) ? a_neg : (a_neg ^ b_neg);
                    rd_d    = dest_reg_sel;
                end else begin
                    out_valid_d  = 1'b1;
                    out_result_d = sc_res;
                    out_addr_d   = agen;
                    out_dest_d   = (branch || mem_write) ? 5'd0 : dest_reg_sel;
                    out_mw_d     = mem_write;
                    out_mr_d     = mem_to_reg;
                    redirect_d   = jal || jalr || (branch && taken);
                    rpc_d        = jalr ? {agen[XLEN-1:1], 1'b0} : ptgt;
                end
            end
            MUL: begin
                acc_d = mul_sum[XLEN:1];
                mq_d  = {mul_sum[0], mq_q[XLEN-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            DIV: begin
                if (!div_diff[XLEN]) begin
                    acc_d = div_diff[XLEN-1:0];
                    mq_d  = {mq_q[XLEN-2:0], 1'b1};
                end else begin
                    acc_d = div_sh[XLEN-1:0];
                    mq_d  = {mq_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            default: begin // FIX: wait for the output slot to free up
                if (!out_valid_q || out_ready) begin
                    state_d      = IDLE;
                    out_valid_d  = 1'b1;
                    out_result_d = fix_res;
                    out_dest_d   = rd_q;
                    out_mw_d     = 1'b0;
                    out_mr_d     = 1'b0;
                    redirect_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            mq_q         <= '0;
            b_q          <= '0;
            op_q         <= '0;
            neg_q        <= 1'b0;
            rd_q         <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_addr_q   <= RESET;
            out_dest_q   <= '0;
            out_mw_q     <= 1'b0;
            out_mr_q     <= 1'b0;
            redirect_q   <= 1'b0;
            rpc_q        <= RESET;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mq_q         <= mq_d;
            b_q          <= b_d;
            op_q         <= op_d;
            neg_q        <= neg_d;
            rd_q         <= rd_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_addr_q   <= out_addr_d;
            out_dest_q   <= out_dest_d;
            out_mw_q     <= out_mw_d;
            out_mr_q     <= out_mr_d;
            redirect_q   <= redirect_d;
            rpc_q        <= rpc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_addr       = out_addr_q;
    assign out_dest_reg   = out_dest_q;
    assign out_mem_write  = out_mw_q;
    assign out_mem_to_reg = out_mr_q;
    assign redirect       = redirect_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_execute_pipe.sv
// Scoreboard bench for execute_pipe (XLEN=32): the driver pushes the
// hand-computed response of each instruction; a negedge monitor pops and
// compares on every output transfer.
module tb_execute_pipe;
    localparam logic [31:0] RST_VAL = 32'hFFFF_0000;
    localparam logic [7:0] C_ALU = 8'h80, C_MD = 8'h40, C_BR = 8'h20, C_LUI = 8'h10,
                           C_JAL = 8'h08, C_JALR = 8'h04, C_ST = 8'h02;

    logic        clk = 1'b0, rst_n;
    logic        in_valid, in_ready, immediate_sel, arithsubtype;
    logic [31:0] pc, reg_rdata1, reg_rdata2, immediate;
    logic        alu, muldiv, branch, lui, jal, jalr, mem_write, mem_to_reg;
    logic [2:0]  alu_operation;
    logic [4:0]  dest_reg_sel;
    logic        out_valid, out_ready, out_mem_write, out_mem_to_reg, redirect;
    logic [31:0] out_result, out_addr, redirect_pc;
    logic [4:0]  out_dest_reg;

    execute_pipe #(.XLEN(32), .RESET(RST_VAL)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
        .immediate(immediate), .immediate_sel(immediate_sel),
        .alu(alu), .muldiv(muldiv), .branch(branch), .lui(lui), .jal(jal),
        .jalr(jalr), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .alu_operation(alu_operation), .arithsubtype(arithsubtype),
        .dest_reg_sel(dest_reg_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_addr(out_addr), .out_dest_reg(out_dest_reg),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [4:0]  dest;
        bit          redir;
        logic [31:0] rpc;
        logic [31:0] addr;
        bit          caddr;
        bit          mw;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0, n_fail = 0, vid = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", nm, act, want);
        end
    endtask

    // Monitor: a transfer happens at the next posedge whenever valid&&ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL unexpected_output got result=%h expected none", out_result);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_result", e.id), out_result, e.res);
                chk($sformatf("v%0d_dest", e.id), 32'(out_dest_reg), 32'(e.dest));
                chk($sformatf("v%0d_redirect", e.id), 32'(redirect), 32'(e.redir));
                chk($sformatf("v%0d_memwrite", e.id), 32'(out_mem_write), 32'(e.mw));
                if (e.redir) chk($sformatf("v%0d_redirect_pc", e.id), redirect_pc, e.rpc);
                if (e.caddr) chk($sformatf("v%0d_addr", e.id), out_addr, e.addr);
                if (e.cyc >= 0) chk($sformatf("v%0d_latency", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one instruction; lat<0 skips the latency check, ewait<0 skips
    // the check on how many cycles in_ready stayed low before acceptance.
    task automatic op(input logic [7:0] cls, input logic [2:0] f3, input bit sub,
                      input bit isel, input logic [31:0] pc_i, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                      input logic [31:0] eres, input logic [4:0] edest, input bit eredir,
                      input logic [31:0] erpc, input logic [31:0] eaddr, input bit caddr,
                      input int lat, input int ewait);
        exp_t e;
        int w;
        @(negedge clk);
        {alu, muldiv, branch, lui, jal, jalr, mem_write, mem_to_reg} = cls;
        alu_operation = f3; arithsubtype = sub; immediate_sel = isel;
        pc = pc_i; reg_rdata1 = a; reg_rdata2 = b; immediate = imm; dest_reg_sel = rd;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            n_vec++; n_fail++;
            $display("FAIL issue_timeout got in_ready=0 expected 1 (vector %0d)", vid);
            in_valid = 1'b0;
            return;
        end
        if (ewait >= 0) chk($sformatf("v%0d_inready_low_cycles", vid), 32'(w), 32'(ewait));
        e.id = vid; e.res = eres; e.dest = edest; e.redir = eredir; e.rpc = erpc;
        e.addr = eaddr; e.caddr = caddr; e.mw = cls[1];
        e.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
        sb.push_back(e);
        vid++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_vec++; n_fail++;
            $display("FAIL drain_timeout got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        {alu, muldiv, branch, lui, jal, jalr, mem_write, mem_to_reg} = '0;
        alu_operation = '0; arithsubtype = 1'b0; immediate_sel = 1'b0;
        pc = '0; reg_rdata1 = '0; reg_rdata2 = '0; immediate = '0; dest_reg_sel = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_addr", out_addr, RST_VAL);
        chk("rst_redirect_pc", redirect_pc, RST_VAL);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_dest", 32'(out_dest_reg), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Single-cycle ops, issued back to back.
        op(C_ALU, 3'd0, 0, 0, 0, 32'd5, 32'd7, 0, 5'd1, 32'd12, 5'd1, 0, 0, 0, 0, 0, 0);
        op(C_ALU, 3'd0, 1, 0, 0, 32'd5, 32'd7, 0, 5'd2, 32'hFFFF_FFFE, 5'd2, 0, 0, 0, 0, 0, 0);
        op(C_ALU, 3'd5, 0, 1, 0, 32'h8000_0000, 0, 32'd4, 5'd3, 32'h0800_0000, 5'd3, 0, 0, 0, 0, 0, 0);
        op(C_ALU, 3'd5, 1, 1, 0, 32'h8000_0000, 0, 32'd4, 5'd4, 32'hF800_0000, 5'd4, 0, 0, 0, 0, 0, 0);
        op(C_ALU, 3'd2, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 5'd5, 32'd1, 5'd5, 0, 0, 0, 0, 0, 0);
        op(C_ALU, 3'd3, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 0, 5'd6, 32'd0, 5'd6, 0, 0, 0, 0, 0, 0);
        op(C_LUI, 3'd0, 0, 1, 0, 0, 0, 32'h1234_5000, 5'd7, 32'h1234_5000, 5'd7, 0, 0, 0, 0, 0, 0);
        op(C_ST, 3'd2, 0, 1, 0, 32'h1000, 32'hDEAD, 32'd8, 5'd9, 32'hDEAD, 5'd0, 0, 0, 32'h1008, 1, 0, 0);
        op(C_BR, 3'd4, 0, 0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd8, 32'd0, 5'd0, 1, 32'h120, 0, 0, 0, 0);
        op(C_BR, 3'd6, 0, 0, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd8, 32'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        op(C_JALR, 3'd0, 0, 1, 32'h200, 32'h1001, 0, 32'd2, 5'd1, 32'h204, 5'd1, 1, 32'h1002, 0, 0, 0, 0);

        // Multi-cycle muldiv: 33-cycle latency, in_ready low for 33 samples.
        op(C_MD, 3'd0, 0, 0, 0, 32'hFFFF_FFFE, 32'd3, 0, 5'd10, 32'hFFFF_FFFA, 5'd10, 0, 0, 0, 0, 33, 0);
        op(C_MD, 3'd1, 0, 0, 0, 32'hFFFF_FFFE, 32'd3, 0, 5'd11, 32'hFFFF_FFFF, 5'd11, 0, 0, 0, 0, 33, 33);
        op(C_MD, 3'd3, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 5'd12, 32'hFFFF_FFFE, 5'd12, 0, 0, 0, 0, 33, 33);
        op(C_MD, 3'd4, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 5'd13, 32'hFFFF_FFFD, 5'd13, 0, 0, 0, 0, 33, 33);
        op(C_MD, 3'd6, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 5'd14, 32'hFFFF_FFFF, 5'd14, 0, 0, 0, 0, 33, 33);
        // Divide special cases complete in a single cycle.
        op(C_MD, 3'd5, 0, 0, 0, 32'd5, 32'd0, 0, 5'd15, 32'hFFFF_FFFF, 5'd15, 0, 0, 0, 0, 0, 33);
        op(C_MD, 3'd6, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 5'd16, 32'd0, 5'd16, 0, 0, 0, 0, 0, 0);
        op(C_MD, 3'd4, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 5'd17, 32'h8000_0000, 5'd17, 0, 0, 0, 0, 0, 0);
        op(C_JAL, 3'd0, 0, 1, 32'h300, 32'h1000, 0, 32'h40, 5'd18, 32'h304, 5'd18, 1, 32'h340, 32'h1040, 1, 0, 0);
        drain();

        // Back-pressure at DIVU completion: held 5 cycles, then one transfer.
        @(posedge clk);
        #1 out_ready = 1'b0;
        op(C_MD, 3'd5, 0, 0, 0, 32'd100, 32'd7, 0, 5'd19, 32'd14, 5'd19, 0, 0, 0, 0, -1, 0);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_result", out_result, 32'd14);
            chk("stall_redirect", 32'(redirect), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("single_transfer_valid", 32'(out_valid), 32'd0);
        chk("single_transfer_pending", 32'(sb.size()), 32'd0);

        // Reset in the middle of a DIV discards it.
        op(C_MD, 3'd4, 0, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 5'd20, 32'hFFFF_FFFD, 5'd20, 0, 0, 0, 0, -1, 0);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", out_result, 32'd0);
        chk("midrst_addr", out_addr, RST_VAL);
        chk("midrst_redirect_pc", redirect_pc, RST_VAL);
        chk("midrst_dest", 32'(out_dest_reg), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        op(C_ALU, 3'd0, 0, 0, 0, 32'd3, 32'd4, 0, 5'd21, 32'd7, 5'd21, 0, 0, 0, 0, 0, 0);
        drain();
        repeat (3) @(negedge clk);
        chk("post_reset_no_stale", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
